guess_entry_ctrl: RTL and testbench

GUESS_ENTRY_CTRL -- requirements
Module: guess_entry_ctrl

---
 rtl/guess_entry_if.sv | 25 ++
 rtl/guess_entry_ctrl.sv | 101 ++++++++++
 tb/tb_guess_entry_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/guess_entry_if.sv
// Bundle of keypad/button inputs, scorer handshake and display/status outputs
// shared by the guess entry controller and whatever drives it.
interface guess_entry_if;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        btn_del;
  logic        btn_enter;
  logic        guess_ready;
  logic        guess_valid;
  logic [15:0] guess;
  logic [2:0]  digit_count;
  logic [3:0]  an;
  logic [3:0]  hex_out;
  logic [15:0] led;

  modport master (
    output key_valid, key_code, btn_del, btn_enter, guess_ready,
    input  guess_valid, guess, digit_count, an, hex_out, led
  );

  modport slave (
    input  key_valid, key_code, btn_del, btn_enter, guess_ready,
    output guess_valid, guess, digit_count, an, hex_out, led
  );
endinterface

// File: rtl/guess_entry_ctrl.sv
// Buffers up to four decimal guess digits from a keypad, hands the packed guess
// to a scorer with a valid/ready handshake and multiplexes the digits onto a display.
module guess_entry_ctrl #(
  parameter int REFRESH_BITS = 17,
  parameter int MAX_DIGITS   = 4
) (
  input  logic         clk,
  input  logic         rst,
  guess_entry_if.slave bus
);

  localparam logic [2:0] FULL = 3'(MAX_DIGITS);

  typedef enum logic {ENTRY, SUBMIT} state_t;

  state_t                  state_q, state_d;
  logic [15:0]             buffer_q, buffer_d;
  logic [2:0]              count_q, count_d;
  logic                    reject;
  logic [3:0]              onehot_d;
  logic [15:0]             led_q;
  logic [REFRESH_BITS-1:0] prescale_q;
  logic [1:0]              sel_q;
  logic                    blank;
  logic [3:0]              an_q, hex_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ENTRY;
      buffer_q <= '0;
      count_q  <= '0;
      led_q    <= '0;
    end else begin
      state_q  <= state_d;
      buffer_q <= buffer_d;
      count_q  <= count_d;
      led_q    <= {reject, 10'b0, state_d == SUBMIT, onehot_d};
    end
  end

  // Position p lives at buffer[15-4p -: 4]; the first digit is the leftmost nibble.
  always_comb begin
    state_d  = state_q;
    buffer_d = buffer_q;
    count_d  = count_q;
    reject   = 1'b0;
    case (state_q)
      ENTRY: begin
        if (bus.btn_enter) begin
          if (count_q == FULL) state_d = SUBMIT;
          else                 reject  = 1'b1;
        end else if (bus.btn_del) begin
          if (count_q != 3'd0) begin
            count_d  = count_q - 3'd1;
            buffer_d = buffer_q & ~(16'hF000 >> {count_d, 2'b00});
          end
        end else if (bus.key_valid && bus.key_code <= 4'd9 && count_q < FULL) begin
          count_d  = count_q + 3'd1;
          buffer_d = buffer_q | ({bus.key_code, 12'h000} >> {count_q, 2'b00});
        end
      end
      SUBMIT: begin
        if (bus.guess_ready) begin
          state_d  = ENTRY;
          buffer_d = '0;
          count_d  = '0;
        end
      end
    endcase
  end

  always_comb begin
    onehot_d = 4'b0001 << count_d[1:0];
    if (count_d == FULL) onehot_d = 4'hF;
  end

  // Free-running scan: the select advances once per full prescaler period.
  assign blank = ({1'b0, sel_q} >= count_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescale_q <= '0;
      sel_q      <= '0;
      an_q       <= 4'hF;
      hex_q      <= '0;
    end else begin
      prescale_q <= prescale_q + REFRESH_BITS'(1);
      if (&prescale_q) sel_q <= sel_q + 2'd1;
      an_q  <= blank ? 4'hF : ~(4'b1000 >> sel_q);
      hex_q <= blank ? 4'h0 : buffer_q[{~sel_q, 2'b00} +: 4];
    end
  end

  assign bus.guess_valid = (state_q == SUBMIT);
  assign bus.guess       = buffer_q;
  assign bus.digit_count = count_q;
  assign bus.an          = an_q;
  assign bus.hex_out     = hex_q;
  assign bus.led         = led_q;

endmodule

// File: tb/tb_guess_entry_ctrl.sv
// Randomized and directed bench for guess_entry_ctrl against a queue-based model
// of the digit buffer and submit handshake.
module tb_guess_entry_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  guess_entry_if bus ();

  guess_entry_ctrl #(.REFRESH_BITS(2), .MAX_DIGITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int digits[$];
  bit submitted;
  bit rejected;

  function automatic logic [15:0] modelGuess();
    logic [15:0] g = '0;
    for (int i = 0; i < digits.size(); i++) g = g | (16'(digits[i]) << (12 - 4 * i));
    return g;
  endfunction

  function automatic logic [15:0] modelLed();
    logic [3:0] oh;
    oh = (digits.size() == 4) ? 4'hF : 4'(1 << digits.size());
    return {rejected, 10'b0, submitted, oh};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  task automatic resetModel();
    digits.delete();
    submitted = 1'b0;
    rejected  = 1'b0;
  endtask

  // One clock: drive at negedge, update the model at posedge, check at the next negedge.
  task automatic applyStimulus(input bit kv, input logic [3:0] code, input bit del,
                               input bit enter, input bit ready);
    bus.key_valid   = kv;
    bus.key_code    = code;
    bus.btn_del     = del;
    bus.btn_enter   = enter;
    bus.guess_ready = ready;
    @(posedge clk);
    rejected = 1'b0;
    if (submitted) begin
      if (ready) begin
        digits.delete();
        submitted = 1'b0;
      end
    end else if (enter) begin
      if (digits.size() == 4) submitted = 1'b1;
      else                    rejected  = 1'b1;
    end else if (del) begin
      if (digits.size() > 0) void'(digits.pop_back());
    end else if (kv && code <= 4'd9 && digits.size() < 4) begin
      digits.push_back(int'(code));
    end
    @(negedge clk);
    bus.key_valid = 1'b0;
    bus.btn_del   = 1'b0;
    bus.btn_enter = 1'b0;
    checkOutput("guess", 32'(bus.guess), 32'(modelGuess()));
    checkOutput("count", 32'(bus.digit_count), digits.size());
    checkOutput("valid", 32'(bus.guess_valid), 32'(submitted));
    checkOutput("led", 32'(bus.led), 32'(modelLed()));
    checkOutput("an_one_low", 32'($countones(~bus.an) <= 1), 32'd1);
    if (bus.an == 4'hF) checkOutput("hex_blank", 32'(bus.hex_out), 32'd0);
  endtask

  task automatic key(input logic [3:0] code);
    applyStimulus(1'b1, code, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input bit ready);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0, ready);
  endtask

  int n0111, n1011, nblank;

  initial begin
    rst = 1'b1;
    bus.key_valid = 1'b0; bus.key_code = 4'h0; bus.btn_del = 1'b0;
    bus.btn_enter = 1'b0; bus.guess_ready = 1'b0;
    resetModel();
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_valid", 32'(bus.guess_valid), 32'd0);
    checkOutput("rst_guess", 32'(bus.guess), 32'd0);
    checkOutput("rst_an", 32'(bus.an), 32'hF);
    checkOutput("rst_hex", 32'(bus.hex_out), 32'd0);
    checkOutput("rst_led", 32'(bus.led), 32'd0);
    checkOutput("rst_count", 32'(bus.digit_count), 32'd0);
    rst = 1'b0;

    // Full guess, held while the scorer stalls, then a one-cycle handshake.
    key(4'd3); key(4'd7); key(4'd1); key(4'd9);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      idle(1'b0);
      checkOutput("hold_guess", 32'(bus.guess), 32'h3719);
      checkOutput("hold_valid", 32'(bus.guess_valid), 32'd1);
    end
    idle(1'b1);
    checkOutput("done_valid", 32'(bus.guess_valid), 32'd0);
    checkOutput("done_count", 32'(bus.digit_count), 32'd0);

    // Delete then re-enter; early enter is rejected with a one-cycle led[15] pulse.
    key(4'd5); key(4'd2);
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    key(4'd8);
    checkOutput("del_guess", 32'(bus.guess), 32'h5800);
    checkOutput("del_count", 32'(bus.digit_count), 32'd2);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("reject_pulse", 32'(bus.led[15]), 32'd1);
    idle(1'b0);
    checkOutput("reject_end", 32'(bus.led[15]), 32'd0);
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("del_empty", 32'(bus.digit_count), 32'd0);

    // Hex keys ignored; a fifth digit never overwrites.
    key(4'hA); key(4'hF);
    checkOutput("hex_keys", 32'(bus.digit_count), 32'd0);
    key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'd5);
    checkOutput("fifth_digit", 32'(bus.guess), 32'h1234);

    // All three events together: enter wins.
    applyStimulus(1'b1, 4'd7, 1'b1, 1'b1, 1'b0);
    checkOutput("prio_valid", 32'(bus.guess_valid), 32'd1);
    checkOutput("prio_guess", 32'(bus.guess), 32'h1234);
    applyStimulus(1'b1, 4'd7, 1'b1, 1'b1, 1'b0);
    checkOutput("submit_ignore", 32'(bus.guess), 32'h1234);
    idle(1'b1);

    // Display scan over one full period with two digits buffered.
    key(4'd6); key(4'd4); idle(1'b0); idle(1'b0);
    n0111 = 0; n1011 = 0; nblank = 0;
    for (int i = 0; i < 16; i++) begin
      idle(1'b0);
      if (bus.an == 4'b0111) begin
        n0111++;
        checkOutput("scan_hex0", 32'(bus.hex_out), 32'd6);
      end else if (bus.an == 4'b1011) begin
        n1011++;
        checkOutput("scan_hex1", 32'(bus.hex_out), 32'd4);
      end else if (bus.an == 4'b1111) begin
        nblank++;
      end
    end
    checkOutput("scan_pos0", n0111, 32'd4);
    checkOutput("scan_pos1", n1011, 32'd4);
    checkOutput("scan_blank", nblank, 32'd8);

    // Reset in the middle of a submit takes effect before any clock edge.
    key(4'd1); key(4'd1);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    idle(1'b0);
    rst = 1'b1;
    #1;
    checkOutput("async_valid", 32'(bus.guess_valid), 32'd0);
    checkOutput("async_an", 32'(bus.an), 32'hF);
    checkOutput("async_count", 32'(bus.digit_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    resetModel();

    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom % 3) == 0, 4'($urandom_range(0, 15)),
                    ($urandom % 8) == 0, ($urandom % 6) == 0, ($urandom % 3) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
